// File: rtl/mdu_iter_if.sv
// Handshake/operand bundle between the EX-stage operand buses and mdu_iter.
// master: pipeline side (drives request and operands); slave: the unit.
interface mdu_iter_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, A, B,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, A, B,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// Multiply is shift-add, divide is restoring; both take WIDTH iterations on
// operand magnitudes and apply sign correction when HI/LO are written.
// Build option: define MDU_DIV_EN to compile in the divide datapath; without
// it, DIV/DIVU are ignored like reserved opcodes.
module mdu_iter #(
  parameter int unsigned WIDTH = 32
) (
  input logic       clk,
  input logic       rstn,
  mdu_iter_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  localparam logic [2:0] OpMult  = 3'd0;
  localparam logic [2:0] OpMultu = 3'd1;
`ifdef MDU_DIV_EN
  localparam logic [2:0] OpDiv   = 3'd2;
  localparam logic [2:0] OpDivu  = 3'd3;
`endif
  localparam logic [2:0] OpMthi  = 3'd4;
  localparam logic [2:0] OpMtlo  = 3'd5;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  // acc: running product high half / partial remainder.
  // low: multiplier being shifted out / dividend shifting into quotient.
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]  low_q, low_d;
  // opd: multiplicand or divisor magnitude.
  logic [WIDTH-1:0]  opd_q, opd_d;
  // neg: product or quotient must be negated at completion.
  logic              neg_q, neg_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;
  logic              done_q, done_d;
`ifdef MDU_DIV_EN
  logic              is_div_q, is_div_d;
  logic              neg_rem_q, neg_rem_d;
  logic              div0_q, div0_d;
  logic [WIDTH:0]    div_shift;
  logic [WIDTH:0]    div_diff;
`endif

  logic              is_signed;
  logic              a_neg, b_neg;
  logic [WIDTH-1:0]  a_mag, b_mag;
  logic [WIDTH:0]    mul_sum;
  logic [WIDTH-1:0]  acc_nxt, low_nxt;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]  res_hi, res_lo;

  // Operand sign capture and magnitude conversion for the accepting edge.
  always_comb begin
`ifdef MDU_DIV_EN
    is_signed = (bus.op == OpMult) || (bus.op == OpDiv);
`else
    is_signed = (bus.op == OpMult);
`endif
    a_neg = is_signed & bus.A[WIDTH-1];
    b_neg = is_signed & bus.B[WIDTH-1];
    a_mag = a_neg ? -bus.A : bus.A;
    b_mag = b_neg ? -bus.B : bus.B;
  end

  // One iteration step of the active operation, plus the corrected result.
  always_comb begin
    mul_sum = {1'b0, acc_q} + (low_q[0] ? {1'b0, opd_q} : '0);
    acc_nxt = mul_sum[WIDTH:1];
    low_nxt = {mul_sum[0], low_q[WIDTH-1:1]};
`ifdef MDU_DIV_EN
    div_shift = {acc_q, low_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opd_q};
    if (is_div_q) begin
      // Top bit of the difference set means the trial subtract went negative.
      acc_nxt = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
      low_nxt = {low_q[WIDTH-2:0], ~div_diff[WIDTH]};
    end
`endif
    prod     = {acc_nxt, low_nxt};
    prod_fix = neg_q ? -prod : prod;
    res_hi   = prod_fix[2*WIDTH-1:WIDTH];
    res_lo   = prod_fix[WIDTH-1:0];
`ifdef MDU_DIV_EN
    if (is_div_q) begin
      // Divide by zero leaves remainder = |A|, so the sign fix yields hi = A.
      res_lo = div0_q ? '1 : (neg_q ? -low_nxt : low_nxt);
      res_hi = neg_rem_q ? -acc_nxt : acc_nxt;
    end
`endif
  end

  // Next-state logic: request decode in IDLE, iteration and completion in RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    low_d   = low_q;
    opd_d   = opd_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
`ifdef MDU_DIV_EN
    is_div_d  = is_div_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          case (bus.op)
            OpMult, OpMultu: begin
              state_d = StRun;
              cnt_d   = '0;
              acc_d   = '0;
              low_d   = b_mag;
              opd_d   = a_mag;
              neg_d   = a_neg ^ b_neg;
`ifdef MDU_DIV_EN
              is_div_d = 1'b0;
`endif
            end
`ifdef MDU_DIV_EN
            OpDiv, OpDivu: begin
              state_d   = StRun;
              cnt_d     = '0;
              acc_d     = '0;
              low_d     = a_mag;
              opd_d     = b_mag;
              neg_d     = a_neg ^ b_neg;
              is_div_d  = 1'b1;
              neg_rem_d = a_neg;
              div0_d    = (bus.B == '0);
            end
`endif
            OpMthi:  hi_d = bus.A;
            OpMtlo:  lo_d = bus.A;
            default: ;
          endcase
        end
      end
      StRun: begin
        acc_d = acc_nxt;
        low_d = low_nxt;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          state_d = StIdle;
          hi_d    = res_hi;
          lo_d    = res_lo;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      acc_q   <= '0;
      low_q   <= '0;
      opd_q   <= '0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
`ifdef MDU_DIV_EN
      is_div_q  <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      low_q   <= low_d;
      opd_q   <= opd_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
`ifdef MDU_DIV_EN
      is_div_q  <= is_div_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
`endif
    end
  end

  assign bus.busy = (state_q == StRun);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed vectors plus randomized ops
// compared against an arithmetic reference of HI/LO.
module tb_mdu_iter;

`ifdef MDU_DIV_EN
  localparam bit DivEn = 1'b1;
`else
  localparam bit DivEn = 1'b0;
`endif

  logic clk;
  logic rstn;
  int   checks;
  int   failures;
  logic [31:0] hi_m;
  logic [31:0] lo_m;

  mdu_iter_if #(.WIDTH(32)) bus ();

  mdu_iter #(.WIDTH(32)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference result {hi, lo} from plain arithmetic.
  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, sq, sr;
    logic [63:0] ua, ub, q64, r64, res;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    res = '0;
    case (op)
      3'd0: res = sa * sb;
      3'd1: res = ua * ub;
      3'd2: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = {32'd0, 32'h8000_0000};
        else begin
          sq = sa / sb;
          sr = sa % sb;
          q64 = sq;
          r64 = sr;
          res = {r64[31:0], q64[31:0]};
        end
      end
      3'd3: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else begin
          q64 = ua / ub;
          r64 = ua % ub;
          res = {r64[31:0], q64[31:0]};
        end
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  // Issue one request now (caller sits just after an edge). Long ops return
  // in the cycle done is expected high; other ops return after the accept edge.
  task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit spam);
    logic [31:0] exp_hi, exp_lo;
    logic [63:0] r;
    bit long_op;
    bit bad;
    int nbusy;
    exp_hi  = hi_m;
    exp_lo  = lo_m;
    long_op = 1'b0;
    if (op <= 3'd1 || ((op == 3'd2 || op == 3'd3) && DivEn)) begin
      long_op = 1'b1;
      r = ref_result(op, a, b);
      exp_hi = r[63:32];
      exp_lo = r[31:0];
    end else if (op == 3'd4) begin
      exp_hi = a;
    end else if (op == 3'd5) begin
      exp_lo = a;
    end
    bus.start = 1'b1;
    bus.op    = op;
    bus.A     = a;
    bus.B     = b;
    step();
    bus.start = 1'b0;
    bus.A     = $urandom;
    bus.B     = $urandom;
    if (!long_op) begin
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== exp_hi || bus.lo !== exp_lo) begin
        failures++;
        $display("FAIL %s short_op: busy=%b done=%b hi=%h lo=%h want busy=0 done=0 hi=%h lo=%h",
                 name, bus.busy, bus.done, bus.hi, bus.lo, exp_hi, exp_lo);
      end
      hi_m = exp_hi;
      lo_m = exp_lo;
      return;
    end
    bad   = 1'b0;
    nbusy = 0;
    for (int i = 0; i < 32; i++) begin
      if (bus.busy === 1'b1) nbusy++;
      if (bus.done !== 1'b0 || bus.hi !== hi_m || bus.lo !== lo_m) bad = 1'b1;
      if (spam) begin
        bus.start = 1'b1;
        bus.op    = 3'($urandom_range(0, 7));
        bus.A     = $urandom;
        bus.B     = $urandom;
      end
      step();
    end
    bus.start = 1'b0;
    checks++;
    if (nbusy != 32) begin
      failures++;
      $display("FAIL %s busy_cycles: got %0d want 32", name, nbusy);
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL %s run_hold: done or hi/lo changed during RUN (want hi=%h lo=%h)",
               name, hi_m, lo_m);
    end
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL %s completion: done=%b busy=%b want done=1 busy=0", name, bus.done, bus.busy);
    end
    checks++;
    if (bus.hi !== exp_hi || bus.lo !== exp_lo) begin
      failures++;
      $display("FAIL %s result: hi=%h lo=%h want hi=%h lo=%h", name, bus.hi, bus.lo, exp_hi, exp_lo);
    end
    hi_m = exp_hi;
    lo_m = exp_lo;
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.hi !== hi_m || bus.lo !== lo_m) begin
      failures++;
      $display("FAIL %s idle: done=%b busy=%b hi=%h lo=%h want 0 0 %h %h",
               name, bus.done, bus.busy, bus.hi, bus.lo, hi_m, lo_m);
    end
  endtask

  task automatic test_reset();
    rstn      = 1'b0;
    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.A     = '0;
    bus.B     = '0;
    repeat (3) step();
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      failures++;
      $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h want all 0",
               bus.busy, bus.done, bus.hi, bus.lo);
    end
    rstn = 1'b1;
    hi_m = '0;
    lo_m = '0;
    step();
  endtask

  task automatic test_vectors();
    do_op("mult_neg3x5", 3'd0, 32'hFFFF_FFFD, 32'd5, 1'b0);
    step();
    check_idle("mult_neg3x5_after");
    do_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    step();
    do_op("div_neg7_2", 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    step();
    do_op("divu_by0", 3'd3, 32'd7, 32'd0, 1'b0);
    step();
    do_op("div_neg_by0", 3'd2, 32'hFFFF_FFF9, 32'd0, 1'b0);
    step();
    do_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    step();
    do_op("mult_minsq", 3'd0, 32'h8000_0000, 32'h8000_0000, 1'b0);
    step();
  endtask

  task automatic test_mt_stream();
    do_op("mthi", 3'd4, 32'h1234_5678, 32'd0, 1'b0);
    do_op("mtlo", 3'd5, 32'h0BAD_CAFE, 32'd0, 1'b0);
    do_op("mult_2x3_spam", 3'd0, 32'd2, 32'd3, 1'b1);
    step();
    check_idle("single_done");
  endtask

  task automatic test_reserved();
    do_op("mthi_pre", 3'd4, 32'hA5A5_0001, 32'd0, 1'b0);
    do_op("rsv6", 3'd6, 32'h1111_1111, 32'd2, 1'b0);
    do_op("rsv7", 3'd7, 32'h2222_2222, 32'd3, 1'b0);
    step();
    check_idle("rsv_after");
  endtask

  task automatic test_back_to_back();
    do_op("b2b_0", 3'd1, $urandom, $urandom, 1'b0);
    do_op("b2b_1", 3'd0, $urandom, $urandom, 1'b0);
    do_op("b2b_2", 3'd3, $urandom, $urandom, 1'b0);
    do_op("b2b_3", 3'd2, $urandom, $urandom, 1'b0);
    do_op("b2b_mtlo", 3'd5, 32'h5555_AAAA, 32'd0, 1'b0);
    step();
    check_idle("b2b_after");
  endtask

  task automatic test_mid_reset();
    do_op("mthi_nz", 3'd4, 32'hCAFE_F00D, 32'd0, 1'b0);
    bus.start = 1'b1;
    bus.op    = 3'd1;
    bus.A     = 32'hFFFF_FFFF;
    bus.B     = 32'hFFFF_FFFF;
    step();
    bus.start = 1'b0;
    repeat (10) step();
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_running: busy=%b want 1", bus.busy);
    end
    rstn = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      failures++;
      $display("FAIL mid_reset_clear: busy=%b done=%b hi=%h lo=%h want all 0",
               bus.busy, bus.done, bus.hi, bus.lo);
    end
    step();
    rstn = 1'b1;
    hi_m = '0;
    lo_m = '0;
    step();
    check_idle("mid_reset_idle");
    do_op("multu_4x4", 3'd1, 32'd4, 32'd4, 1'b0);
    step();
  endtask

  task automatic test_random();
    logic [31:0] specials [6];
    logic [31:0] a, b;
    logic [2:0] op;
    specials[0] = 32'd0;
    specials[1] = 32'd1;
    specials[2] = 32'hFFFF_FFFF;
    specials[3] = 32'h8000_0000;
    specials[4] = 32'h7FFF_FFFF;
    specials[5] = 32'd2;
    for (int n = 0; n < 40; n++) begin
      op = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
      do_op($sformatf("rand%0d_op%0d", n, op), op, a, b, $urandom_range(0, 1) == 1);
      repeat ($urandom_range(0, 2)) step();
    end
    step();
    check_idle("rand_after");
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    hi_m     = '0;
    lo_m     = '0;
    test_reset();
    test_vectors();
    test_mt_stream();
    test_reserved();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
# mdu_iter

Iterative multiply/divide unit in the EX stage, beside `alu`, fed by the same ID/EX operand buses (A = rs, B = rt). It executes MULT/MULTU/DIV/DIVU over 32 cycles and holds the architectural HI/LO registers. It also serves MTHI/MTLO writes and supplies HI/LO to the MFHI/MFLO result mux. The pipeline stalls on `busy`.

## Interface
- `WIDTH`, 32, operand/HI/LO width; iteration count equals WIDTH.
- `clk` input 1: single clock, rising edge.
- `rstn` input 1: asynchronous, active-low reset.
- `start` input 1: operation request, sampled at a rising edge.
- `op` input 3: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6–7 reserved.
- `A` input WIDTH: rs operand (multiplicand/dividend; MTHI/MTLO source).
- `B` input WIDTH: rt operand (multiplier/divisor).
- `busy` output 1: iteration in progress; upstream must hold/stall.
- `done` output 1: one-cycle pulse; HI/LO carry the new result.
- `hi` output WIDTH: HI register.
- `lo` output WIDTH: LO register.

## Operation
- States: IDLE, RUN.
- IDLE:
  - With `start` and op 0–3: latch A, B, op and operand signs; clear the iteration counter; go to RUN.
  - Signed ops use magnitudes internally and sign-correct at completion.
- RUN:
  - One iteration per cycle: shift-add for multiply, restoring subtract-shift for divide.
  - After the 32nd iteration: write HI/LO, pulse `done`, go to IDLE.
- MTHI/MTLO (op 4/5) with `start` in IDLE:
  - Write A to hi/lo at that edge.
  - No `busy`, no `done`.
- Reserved ops with `start`: ignored, no state change.
- `start` while `busy`: ignored; the in-flight operation is unaffected.
- hi/lo hold their old values throughout RUN and are updated only at completion.
- Multiply results: {hi,lo} = full 64-bit product, signed or unsigned per op.
- Divide results:
  - lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - Divide by zero, both DIV and DIVU: lo = all ones, hi = A.
  - Signed overflow (A = 0x80000000, B = 0xFFFFFFFF): lo = 0x80000000, hi = 0.
  - Both special cases still take the full 32 cycles.
- Reset, asynchronous, including mid-operation: state = IDLE, `busy` = 0, `done` = 0, hi = 0, lo = 0, counter = 0. The in-flight operation is discarded.

## Timing
- Reset values: busy 0, done 0, hi 0, lo 0.
- Edge E0: `start` accepted; `busy` = 1 after E0.
- Edges E1..E32: iterations. At E32, hi/lo are written, `busy` falls and `done` rises.
- `done` is high for exactly the cycle after E32. `busy` is high for exactly 32 cycles.
- A new `start` is accepted at E33, the cycle in which `done` = 1. Back-to-back throughput is one op per 33 cycles.
- MTHI/MTLO: hi/lo are visible one cycle after the accepting edge.
- `hi` and `lo` are registered outputs, with no combinational path from inputs.

## Configuration
- `MDU_DIV_EN` defined:
  - Divide datapath is compiled in; DIV/DIVU behave as specified.
- `MDU_DIV_EN` undefined:
  - Divide datapath is removed.
  - op 2/3 are treated as reserved: ignored, no `busy`, no `done`, hi/lo unchanged.
  - Multiply and MTHI/MTLO are unaffected.

## Test plan
- MULT, A = 0xFFFFFFFD (−3), B = 5 → `busy` for 32 cycles, then `done` pulse; hi = 0xFFFFFFFF, lo = 0xFFFFFFF1.
- MULTU, A = B = 0xFFFFFFFF → hi = 0xFFFFFFFE, lo = 0x00000001.
- DIV, A = 0xFFFFFFF9 (−7), B = 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. DIVU, A = 7, B = 0 → lo = 0xFFFFFFFF, hi = 7.
- DIV, A = 0x80000000, B = 0xFFFFFFFF → lo = 0x80000000, hi = 0.
- MTHI 0x12345678, then MULT 2×3 with `start` re-asserted every cycle while busy → hi = 0x12345678 until completion, then hi = 0, lo = 6; exactly one `done` pulse.
- Start MULTU 0xFFFFFFFF×0xFFFFFFFF, assert `rstn` = 0 at cycle 10 of RUN → busy/done/hi/lo = 0 immediately. After release, MULTU 4×4 → lo = 16 after 32 cycles.
